// File: rtl/prog_counter_pkg.sv
// Shared types and constants for the programmable up/down counter.
package prog_counter_pkg;

  // Width of the prescaler cycle counter (PRESCALE up to 65535).
  localparam int unsigned PS_W = 16;

  // Count direction as sampled from up_dn.
  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

  // Boundary behaviour as sampled from sat_mode.
  typedef enum logic {
    MODE_WRAP = 1'b0,
    MODE_SAT  = 1'b1
  } mode_e;

endpackage : prog_counter_pkg

// File: rtl/prog_counter_prescaler.sv
// Prescaler: issues a tick on every PRESCALE-th enabled cycle.
// A low enable freezes the cycle count; restart zeroes it so that the next
// tick needs a full PRESCALE enabled cycles.
module prog_counter_prescaler
  import prog_counter_pkg::*;
#(
  parameter int unsigned PRESCALE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic restart,
  output logic tick
);

  localparam logic [PS_W-1:0] TERM = PS_W'(PRESCALE - 1);

  logic [PS_W-1:0] cnt_q;
  logic [PS_W-1:0] cnt_d;
  logic            tick_c;

  // Next-state for the enabled-cycle counter and the combinational tick.
  always_comb begin
    cnt_d  = cnt_q;
    tick_c = enable && (cnt_q == TERM);
    if (restart) begin
      cnt_d = '0;
    end else if (tick_c) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = cnt_q + PS_W'(1);
    end
  end

  assign tick = tick_c;

  // Enabled-cycle counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule : prog_counter_prescaler

// File: rtl/prog_counter.sv
// Programmable modulo up/down counter with prescaler, wrap/saturate modes,
// one-cycle terminal-count pulse and a sticky boundary flag.
// Optional input capture register enabled by defining PROG_COUNTER_CAPTURE_EN.
module prog_counter
  import prog_counter_pkg::*;
#(
  parameter int unsigned      WIDTH    = 8,
  parameter logic [WIDTH-1:0] MOD_VAL  = {WIDTH{1'b1}},
  parameter int unsigned      PRESCALE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             up_dn,
  input  logic             sat_mode,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             ovf_clr,
`ifdef PROG_COUNTER_CAPTURE_EN
  input  logic             capture,
  output logic [WIDTH-1:0] cap_val,
`endif
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             ovf
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic             tc_q;
  logic             tc_d;
  logic             ovf_q;
  logic             ovf_d;
  logic             tick;
  logic             restart_c;
  logic             boundary_c;
  dir_e             dir_c;
  mode_e            mode_c;

  // clear and load both restart the prescaler.
  assign restart_c = clear | load;

  prog_counter_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk     (clk),
    .reset   (reset),
    .enable  (enable),
    .restart (restart_c),
    .tick    (tick)
  );

  // Next count, tc and ovf: clear > load > step > hold.
  always_comb begin
    count_d    = count_q;
    tc_d       = 1'b0;
    ovf_d      = ovf_q & ~ovf_clr;
    boundary_c = 1'b0;
    dir_c      = dir_e'(up_dn);
    mode_c     = mode_e'(sat_mode);

    if (clear) begin
      count_d = '0;
    end else if (load) begin
      count_d = (load_val > MOD_VAL) ? MOD_VAL : load_val;
    end else if (tick) begin
      if (dir_c == DIR_UP) begin
        if (count_q >= MOD_VAL) begin
          boundary_c = 1'b1;
          count_d    = (mode_c == MODE_SAT) ? MOD_VAL : '0;
        end else begin
          count_d = count_q + WIDTH'(1);
        end
      end else begin
        if (count_q == '0) begin
          boundary_c = 1'b1;
          count_d    = (mode_c == MODE_SAT) ? '0 : MOD_VAL;
        end else begin
          count_d = count_q - WIDTH'(1);
        end
      end
    end

    // A new boundary crossing wins over a coincident ovf_clr.
    if (boundary_c) begin
      tc_d  = 1'b1;
      ovf_d = 1'b1;
    end
  end

  // Counter state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      tc_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
      ovf_q   <= ovf_d;
    end
  end

  assign count = count_q;
  assign tc    = tc_q;
  assign ovf   = ovf_q;

`ifdef PROG_COUNTER_CAPTURE_EN
  logic [WIDTH-1:0] cap_val_q;
  logic [WIDTH-1:0] cap_val_d;

  // Capture holds the count as it stood before this edge's update.
  always_comb begin
    cap_val_d = cap_val_q;
    if (capture) begin
      cap_val_d = count_q;
    end
  end

  // Capture register.
  always_ff @(posedge clk) begin
    if (reset) begin
      cap_val_q <= '0;
    end else begin
      cap_val_q <= cap_val_d;
    end
  end

  assign cap_val = cap_val_q;
`endif

endmodule : prog_counter

// File: tb/tb_prog_counter.sv
// Scoreboard bench for prog_counter: two instances (PRESCALE=1 and 4) share
// stimulus; each driven cycle queues the expected post-edge state of one of
// them, and a monitor compares after every rising edge.
module tb_prog_counter;

  typedef struct {
    bit         sel;
    logic [7:0] count;
    logic       tc;
    logic       ovf;
    logic [7:0] cap;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       en;
  logic       ud;
  logic       sm;
  logic       cl;
  logic       ld;
  logic [7:0] lv;
  logic       oc;
  logic       cap_in;
  logic [7:0] exp_cap;

  logic [7:0] count0, count1;
  logic       tc0, tc1, ovf0, ovf1;
`ifdef PROG_COUNTER_CAPTURE_EN
  logic [7:0] cap_val0, cap_val1;
`endif

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  prog_counter #(
    .WIDTH    (8),
    .MOD_VAL  (8'd9),
    .PRESCALE (1)
  ) u_dut (
    .clk      (clk),
    .reset    (rst),
    .enable   (en),
    .up_dn    (ud),
    .sat_mode (sm),
    .clear    (cl),
    .load     (ld),
    .load_val (lv),
    .ovf_clr  (oc),
`ifdef PROG_COUNTER_CAPTURE_EN
    .capture  (cap_in),
    .cap_val  (cap_val0),
`endif
    .count    (count0),
    .tc       (tc0),
    .ovf      (ovf0)
  );

  prog_counter #(
    .WIDTH    (8),
    .MOD_VAL  (8'd9),
    .PRESCALE (4)
  ) u_dut_ps4 (
    .clk      (clk),
    .reset    (rst),
    .enable   (en),
    .up_dn    (ud),
    .sat_mode (sm),
    .clear    (cl),
    .load     (ld),
    .load_val (lv),
    .ovf_clr  (oc),
`ifdef PROG_COUNTER_CAPTURE_EN
    .capture  (cap_in),
    .cap_val  (cap_val1),
`endif
    .count    (count1),
    .tc       (tc1),
    .ovf      (ovf1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int idx, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s entry %0d: got %0d expected %0d", name, idx, got, want);
    end
  endtask

  // Drive one cycle (inputs settle at the falling edge), queue expected result.
  task automatic drive(input bit s, input logic r, input logic e, input logic c, input logic l,
                       input logic [7:0] v, input logic o,
                       input logic [7:0] ec, input logic et, input logic eo);
    exp_t x;
    rst = r; en = e; cl = c; ld = l; lv = v; oc = o;
    x.sel = s; x.count = ec; x.tc = et; x.ovf = eo; x.cap = exp_cap;
    sb.push_back(x);
    @(negedge clk);
  endtask

  // Monitor: one queued expectation per rising edge.
  initial begin : monitor
    exp_t x;
    int   idx;
    idx = 0;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        x = sb.pop_front();
        if (x.sel) begin
          check("count_ps4", idx, 32'(count1), 32'(x.count));
          check("tc_ps4",    idx, 32'(tc1),    32'(x.tc));
          check("ovf_ps4",   idx, 32'(ovf1),   32'(x.ovf));
`ifdef PROG_COUNTER_CAPTURE_EN
          check("cap_ps4",   idx, 32'(cap_val1), 32'(x.cap));
`endif
        end else begin
          check("count", idx, 32'(count0), 32'(x.count));
          check("tc",    idx, 32'(tc0),    32'(x.tc));
          check("ovf",   idx, 32'(ovf0),   32'(x.ovf));
`ifdef PROG_COUNTER_CAPTURE_EN
          check("cap",   idx, 32'(cap_val0), 32'(x.cap));
`endif
        end
        idx++;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    rst = 1'b1; en = 1'b0; ud = 1'b1; sm = 1'b0; cl = 1'b0; ld = 1'b0;
    lv = 8'd0; oc = 1'b0; cap_in = 1'b0; exp_cap = 8'd0;
    @(negedge clk);

    // Reset state of both instances.
    drive(0, 1, 0, 0, 0, 8'd0, 0, 8'd0, 0, 0);
    drive(1, 1, 0, 0, 0, 8'd0, 0, 8'd0, 0, 0);

    // Up, wrap, 12 enabled cycles: 1..9,0,1,2; tc after 9->0; ovf sticky.
    ud = 1'b1; sm = 1'b0;
    for (int k = 1; k <= 12; k++)
      drive(0, 0, 1, 0, 0, 8'd0, 0, 8'(k % 10), (k == 10), (k >= 10));
    drive(0, 0, 0, 0, 0, 8'd0, 1, 8'd2, 0, 0);

    // Saturate up at 9: count holds, tc on every tick.
    sm = 1'b1;
    drive(0, 0, 1, 0, 1, 8'd9, 0, 8'd9, 0, 0);
    for (int k = 0; k < 3; k++)
      drive(0, 0, 1, 0, 0, 8'd0, 0, 8'd9, 1, 1);
    drive(0, 0, 0, 0, 0, 8'd0, 0, 8'd9, 0, 1);

    // ovf_clr coincident with a boundary step keeps ovf; alone clears it.
    drive(0, 0, 1, 0, 0, 8'd0, 1, 8'd9, 1, 1);
    drive(0, 0, 0, 0, 0, 8'd0, 1, 8'd9, 0, 0);

    // Down, wrap: load 0, step -> 9 with tc; load 200 clamps to 9, no tc.
    ud = 1'b0; sm = 1'b0;
    drive(0, 0, 1, 0, 1, 8'd0,   0, 8'd0, 0, 0);
    drive(0, 0, 1, 0, 0, 8'd0,   0, 8'd9, 1, 1);
    drive(0, 0, 1, 0, 1, 8'd200, 0, 8'd9, 0, 1);
    drive(0, 0, 1, 0, 0, 8'd0,   0, 8'd8, 0, 1);

    // Down, saturate at 0.
    sm = 1'b1;
    drive(0, 0, 1, 0, 1, 8'd0, 0, 8'd0, 0, 1);
    drive(0, 0, 1, 0, 0, 8'd0, 0, 8'd0, 1, 1);
    sm = 1'b0;

    // clear beats load and leaves ovf alone.
    ud = 1'b1;
    drive(0, 0, 1, 1, 1, 8'd5, 0, 8'd0, 0, 1);

`ifdef PROG_COUNTER_CAPTURE_EN
    // Capture at 7 while stepping: cap_val 7, count 8.
    drive(0, 0, 1, 0, 1, 8'd7, 0, 8'd7, 0, 1);
    cap_in = 1'b1; exp_cap = 8'd7;
    drive(0, 0, 1, 0, 0, 8'd0, 0, 8'd8, 0, 1);
    cap_in = 1'b0;
`endif

    // Reset mid-count at 5.
    drive(0, 0, 1, 1, 0, 8'd0, 0, 8'd0, 0, 1);
    for (int k = 1; k <= 5; k++)
      drive(0, 0, 1, 0, 0, 8'd0, 0, 8'(k), 0, 1);
    exp_cap = 8'd0;
    drive(0, 1, 1, 0, 0, 8'd0, 0, 8'd0, 0, 0);
    drive(1, 1, 0, 0, 0, 8'd0, 0, 8'd0, 0, 0);

    // PRESCALE=4 with enable every other cycle: one step per 8 clocks.
    ud = 1'b1; sm = 1'b0;
    for (int k = 1; k <= 16; k++)
      drive(1, 0, logic'(k % 2), 0, 0, 8'd0, 0, 8'(((k + 1) / 2) / 4), 0, 0);

    // Clear mid-prescale; next step needs 4 fresh enabled cycles.
    drive(1, 0, 1, 0, 0, 8'd0, 0, 8'd2, 0, 0);
    drive(1, 0, 1, 0, 0, 8'd0, 0, 8'd2, 0, 0);
    drive(1, 0, 1, 1, 0, 8'd0, 0, 8'd0, 0, 0);
    drive(1, 0, 1, 0, 0, 8'd0, 0, 8'd0, 0, 0);
    drive(1, 0, 1, 0, 0, 8'd0, 0, 8'd0, 0, 0);
    drive(1, 0, 1, 0, 0, 8'd0, 0, 8'd0, 0, 0);
    drive(1, 0, 1, 0, 0, 8'd0, 0, 8'd1, 0, 0);

    // Direction is taken from the tick edge only.
    ud = 1'b0;
    drive(1, 0, 1, 0, 0, 8'd0, 0, 8'd1, 0, 0);
    drive(1, 0, 1, 0, 0, 8'd0, 0, 8'd1, 0, 0);
    drive(1, 0, 1, 0, 0, 8'd0, 0, 8'd1, 0, 0);
    ud = 1'b1;
    drive(1, 0, 1, 0, 0, 8'd0, 0, 8'd2, 0, 0);
    drive(1, 0, 1, 0, 0, 8'd0, 0, 8'd2, 0, 0);
    drive(1, 0, 1, 0, 0, 8'd0, 0, 8'd2, 0, 0);
    drive(1, 0, 1, 0, 0, 8'd0, 0, 8'd2, 0, 0);
    ud = 1'b0;
    drive(1, 0, 1, 0, 0, 8'd0, 0, 8'd1, 0, 0);

    en = 1'b0;
    for (int w = 0; w < 10 && sb.size() > 0; w++) @(negedge clk);
    check("scoreboard_drain", 0, 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_prog_counter
